// File: rtl/rr_mux_sched.sv
// rtl/rr_mux_sched.sv - four-source round-robin scheduler feeding a single registered output slot
//
// Purpose: picks one of four requesting sources in round-robin order, captures
// its word into a one-entry output register and hands it to a ready/valid
// consumer. A new word is captured whenever the slot is empty or being drained
// in the same cycle, so a continuously ready consumer sees one word per cycle.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   req[3:0]   per-source request, req[i] means d<i> is valid
//   d0..d3     source data words (WIDTH bits)
//   gnt[3:0]   combinational one-hot grant, d<i> consumed at this edge
//   sel[1:0]   combinational index of the chosen source (downstream mux select)
//   out_valid  output slot holds an unconsumed word
//   out_ready  consumer accepts the word when out_valid && out_ready
//   out_data   registered captured word
//   out_src    registered index of the source that supplied out_data
//   xfer_cnt   8-bit wrapping count of completed output transfers
//              (present only when RR_MUX_SCHED_XFER_CNT_EN is defined)

module rr_mux_sched #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef RR_MUX_SCHED_XFER_CNT_EN
  output logic [7:0]       xfer_cnt,
`endif
  output logic [1:0]       out_src
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [1:0]       out_src_q,   out_src_d;
  logic [1:0]       last_q,      last_d;

  logic             cap;
  logic             grant;
  logic             found;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic [WIDTH-1:0] sel_data;

  // Scan from the source after the last winner, wrapping; with no request the
  // select parks on the last winner.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    idx   = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign cap   = !out_valid_q || out_ready;
  // rst gates the grant so no source believes its word was taken during reset.
  assign grant = cap && found && !rst;
  assign gnt   = grant ? (4'b0001 << win) : 4'b0000;
  assign sel   = win;

  always_comb begin
    case (sel)
      2'd0:    sel_data = d0;
      2'd1:    sel_data = d1;
      2'd2:    sel_data = d2;
      default: sel_data = d3;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    last_d      = last_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_src_d   = sel;
      last_d      = sel;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // last resets to 3 so the first grant after reset goes to source 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 2'd0;
      last_q      <= 2'd3;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

`ifdef RR_MUX_SCHED_XFER_CNT_EN
  logic [7:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (out_valid_q && out_ready) begin
      xfer_cnt_d = xfer_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt_q <= 8'd0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_rr_mux_sched.sv
// tb/tb_rr_mux_sched.sv - self-checking bench for rr_mux_sched against a behavioural round-robin model

module tb_rr_mux_sched;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;
`ifdef RR_MUX_SCHED_XFER_CNT_EN
  logic [7:0]       xfer_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: one output slot plus the last-winner index.
  bit m_valid;
  int m_data, m_src, m_last, m_cnt;
  int wait_cnt [4];
  logic [3:0] obs_gnt;

  rr_mux_sched #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef RR_MUX_SCHED_XFER_CNT_EN
    .xfer_cnt  (xfer_cnt),
`endif
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // First requesting source at or after (last+1) mod 4, or -1 if none.
  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_data  = 0;
    m_src   = 0;
    m_last  = 3;
    m_cnt   = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
  endtask

  // Called just after a falling edge with inputs already applied: checks the
  // combinational outputs, advances the model across the rising edge, then
  // checks the registered outputs after the next falling edge.
  task automatic step(input string tag);
    int w;
    bit cap, g;
    int dv [4];
    dv[0] = int'(d0); dv[1] = int'(d1); dv[2] = int'(d2); dv[3] = int'(d3);
    #1;
    w   = pick(req, m_last);
    cap = !m_valid || out_ready;
    g   = cap && (w >= 0);
    obs_gnt = gnt;
    check({tag, ":gnt"}, 32'(gnt), g ? 32'(1 << w) : 32'd0);
    check({tag, ":sel"}, 32'(sel), (w >= 0) ? 32'(w) : 32'(m_last));
    if (cap && req != 4'b0000) begin
      for (int i = 0; i < 4; i++) begin
        if (req[i] && !(g && w == i)) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (req[i]) check({tag, ":starve"}, 32'(wait_cnt[i] < 4), 32'd1);
      end
    end
    for (int i = 0; i < 4; i++) if (!req[i]) wait_cnt[i] = 0;
    @(posedge clk);
    if (m_valid && out_ready) m_cnt = (m_cnt + 1) % 256;
    if (g) begin
      m_valid = 1;
      m_data  = dv[w];
      m_src   = w;
      m_last  = w;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
    check({tag, ":out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ":out_data"},  32'(out_data),  32'(m_data));
    check({tag, ":out_src"},   32'(out_src),   32'(m_src));
`ifdef RR_MUX_SCHED_XFER_CNT_EN
    check({tag, ":xfer_cnt"}, 32'(xfer_cnt), 32'(m_cnt));
`endif
  endtask

  // Assert rst between edges and check its effect before any clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    req = 4'b1111;
    #2 rst = 1'b1;
    #1;
    check({tag, ":rst_valid"}, 32'(out_valid), 32'd0);
    check({tag, ":rst_data"},  32'(out_data),  32'd0);
    check({tag, ":rst_src"},   32'(out_src),   32'd0);
    check({tag, ":rst_gnt"},   32'(gnt),       32'd0);
`ifdef RR_MUX_SCHED_XFER_CNT_EN
    check({tag, ":rst_cnt"},   32'(xfer_cnt),  32'd0);
`endif
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_rr  [5];
    logic [3:0] exp_dat [5];
    logic [3:0] exp_wrap [3];
    exp_rr   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_dat  = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
    exp_wrap = '{4'b0010, 4'b1000, 4'b0010};

    rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    model_reset();
    @(negedge clk);
    check("init:valid", 32'(out_valid), 32'd0);
    check("init:data",  32'(out_data),  32'd0);
    check("init:gnt",   32'(gnt),       32'd0);
    rst = 1'b0;

    // Full rotation with every source requesting.
    req = 4'b1111; d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step("rr");
      check("rr:gnt_seq",  32'(obs_gnt),  32'(exp_rr[i]));
      check("rr:data_seq", 32'(out_data), 32'(exp_dat[i]));
    end

    // Backpressure on a single requester.
    req = 4'b0000; out_ready = 1'b1;
    step("drain");
    req = 4'b0100; d2 = 4'd7; out_ready = 1'b0;
    step("bp_cap");
    check("bp_cap:data", 32'(out_data), 32'd7);
    check("bp_cap:src",  32'(out_src),  32'd2);
    for (int i = 0; i < 5; i++) begin
      d2 = 4'(i + 1);
      step("bp_hold");
      check("bp_hold:gnt",   32'(obs_gnt),   32'd0);
      check("bp_hold:valid", 32'(out_valid), 32'd1);
      check("bp_hold:data",  32'(out_data),  32'd7);
    end
    out_ready = 1'b1;
    step("bp_release");
    check("bp_release:gnt", 32'(obs_gnt), 32'b0100);

    // Wrap-around skipping idle sources from last=3.
    async_reset("wrap");
    req = 4'b1010; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("wrap");
      check("wrap:gnt_seq", 32'(obs_gnt), 32'(exp_wrap[i]));
    end

    // Idle requests: slot empties, select parks on last winner.
    req = 4'b0000;
    for (int i = 0; i < 3; i++) step("idle");
    check("idle:sel_last", 32'(sel), 32'd1);

    // Reset while a word is pending.
    req = 4'b0001; d0 = 4'd5; out_ready = 1'b0;
    step("pend");
    check("pend:data", 32'(out_data), 32'd5);
    async_reset("pend_rst");
    req = 4'b1111; out_ready = 1'b1;
    step("post_rst");
    check("post_rst:gnt", 32'(obs_gnt), 32'b0001);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      req = 4'($urandom);
      d0 = WIDTH'($urandom); d1 = WIDTH'($urandom);
      d2 = WIDTH'($urandom); d3 = WIDTH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end

`ifdef RR_MUX_SCHED_XFER_CNT_EN
    // 256 transfers wrap the counter back to zero; then reset mid-count.
    async_reset("cnt");
    req = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 257; i++) step("cnt");
    check("cnt:wrap", 32'(xfer_cnt), 32'd0);
    for (int i = 0; i < 10; i++) step("cnt_mid");
    async_reset("cnt_rst");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_sched.md
RR_MUX_SCHED -- requirements
Module: rr_mux_sched

Interface
REQ-001 Parameter: WIDTH, default 4, data width of each source and of out_data.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  request per source; req[i] high means d<i> holds a valid word.
REQ-005 d0, d1, d2, d3  input  WIDTH each  source data words.
REQ-006 gnt  output  4  one-hot or zero, combinational; gnt[i] high means d<i> is consumed at this clock edge.
REQ-007 sel  output  2  index of the source currently chosen for capture, combinational; drives the downstream 4:1 mux select.
REQ-008 out_valid  output  1  out_data/out_src hold an unconsumed word.
REQ-009 out_ready  input  1  the consumer accepts the word when out_valid && out_ready.
REQ-010 out_data  output  WIDTH  registered captured word.
REQ-011 out_src  output  2  registered index of the source that supplied out_data.

Function
REQ-012 The block SHALL compute the capture-enable as cap = !out_valid || out_ready.
REQ-013 The block SHALL select the round-robin winner as the first i with req[i] high, scanning from (last+1) mod 4 upward and wrapping; last is a 2-bit register.
REQ-014 sel SHALL equal the winner index when any req is high, and SHALL equal last otherwise.
REQ-015 gnt[winner] SHALL be high only when cap && |req; otherwise gnt SHALL be 4'b0000.
REQ-016 On an edge with a grant, the block SHALL load out_data with d<sel>, load out_src with sel, set out_valid, and set last to sel.
REQ-017 On an edge with out_valid && out_ready and no grant, the block SHALL clear out_valid; out_data and out_src SHALL hold their values.
REQ-018 With out_valid && !out_ready, all registers SHALL hold and gnt SHALL be 0 (backpressure).
REQ-019 Simultaneous drain and grant SHALL give back-to-back transfers, 1 word per cycle, with no bubble.
REQ-020 Latency from the grant edge to out_valid SHALL be 1 cycle.
REQ-021 With all four req held high and out_ready held high, grants SHALL cycle 0,1,2,3,0,... with no starvation.
REQ-022 A requester SHALL wait at most 4 grant opportunities.
REQ-023 Changes to req while out_valid is held SHALL not alter out_data.

Reset
REQ-024 Asserting rst at any time, including mid-transfer, SHALL immediately clear out_valid, set out_data to 0, out_src to 0, and last to 3, so that the first grant after reset goes to source 0.
REQ-025 While rst is high, gnt SHALL be 0.
REQ-026 A word pending at reset SHALL be discarded.

Configuration
REQ-027 Macro RR_MUX_SCHED_XFER_CNT_EN: when defined, the block SHALL add an output xfer_cnt (8 bits) that resets to 0 and increments, wrapping 255 to 0, on every out_valid && out_ready edge.
REQ-028 When RR_MUX_SCHED_XFER_CNT_EN is undefined, the xfer_cnt port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 After reset: req=4'b1111, d0..d3=a,b,c,d, out_ready=1 -> gnt 0001,0010,0100,1000,0001 on successive cycles; out_data a,b,c,d,a one cycle later.
REQ-030 req=4'b0100, d2=7, out_ready=0 -> one grant to 2, out_data=7, out_src=2, out_valid stays 1, gnt=0 for 5 cycles; then out_ready=1 -> word drained and gnt resumes.
REQ-031 last=3, req=4'b1010 -> grant to 1, then 3, then 1 (wrap-around skips idle sources).
REQ-032 rst pulsed while out_valid=1 with out_data=5 -> out_valid=0, out_data=0 at once; the next grant with req=4'b1111 goes to source 0.
REQ-033 req=0 for 3 cycles with out_ready=1 -> out_valid=0, gnt=0, sel=last.
REQ-034 With XFER_CNT_EN: 256 transfers -> xfer_cnt returns to 0; reset mid-count -> xfer_cnt=0.
